// File: rtl/pipe_pkg.sv
// Shared widths, control-bit indices and stage payload layouts for the 5-stage core's pipeline registers.
package pipe_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // Stage-boundary payload widths
    localparam int unsigned IFID_DATA_W  = 2 * WORD_W;
    localparam int unsigned IDEX_DATA_W  = 3 * WORD_W + 3 * REG_ADDR_W;
    localparam int unsigned EXMEM_DATA_W = 2 * WORD_W + REG_ADDR_W;
    localparam int unsigned MEMWB_DATA_W = 2 * WORD_W + REG_ADDR_W;

    // IF/ID carries no decoded control; a single bit keeps the vector legal
    localparam int unsigned IFID_CTRL_W  = 1;
    localparam int unsigned IDEX_CTRL_W  = 9;
    localparam int unsigned EXMEM_CTRL_W = 3;
    localparam int unsigned MEMWB_CTRL_W = 2;

    localparam int unsigned CTRL_REGWRITE = 0;
    localparam int unsigned CTRL_MEMTOREG = 1;
    localparam int unsigned CTRL_MEMWRITE = 2;

    typedef struct packed {
        logic [WORD_W-1:0]     pc_plus4;
        logic [WORD_W-1:0]     instr;
    } ifid_bundle_t;

    typedef struct packed {
        logic [WORD_W-1:0]     rd1;
        logic [WORD_W-1:0]     rd2;
        logic [WORD_W-1:0]     sign_imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] rd;
    } idex_bundle_t;

    typedef struct packed {
        logic [WORD_W-1:0]     alu_out;
        logic [WORD_W-1:0]     write_data;
        logic [REG_ADDR_W-1:0] write_reg;
    } exmem_bundle_t;

    typedef struct packed {
        logic [WORD_W-1:0]     read_data;
        logic [WORD_W-1:0]     alu_out;
        logic [REG_ADDR_W-1:0] write_reg;
    } memwb_bundle_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register behind a pipeline stage; holds the word accepted while the main register is stalled.
module pipe_skid_buf #(
    parameter int unsigned DATA_W = 69,
    parameter int unsigned CTRL_W = 3
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Push only happens when empty and pop only when full, so they never collide
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_full <= 1'b0;
            r_data <= '0;
            r_ctrl <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
            r_ctrl <= '0;
        end else if (i_push) begin
            r_full <= 1'b1;
            r_data <= i_data;
            r_ctrl <= i_ctrl;
        end else if (i_pop) begin
            r_full <= 1'b0;
            r_ctrl <= '0;
        end
    end

    assign o_full = r_full;
    assign o_data = r_data;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready, flush-to-bubble and zeroed bubble control.
// Define PIPE_SKID_EN to add a one-entry skid buffer and a registered in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W   = EXMEM_DATA_W,
    parameter int unsigned       CTRL_W   = EXMEM_CTRL_W,
    parameter logic [DATA_W-1:0] DATA_RST = '0
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_load;
    logic              w_src_valid;
    logic [DATA_W-1:0] w_src_data;
    logic [CTRL_W-1:0] w_src_ctrl;

    assign w_load = ~r_valid | out_ready;

`ifdef PIPE_SKID_EN
    logic              w_skid_full;
    logic              w_skid_push;
    logic              w_skid_pop;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;

    // Capture into skid only when the upstream accepts while main is stalled
    assign w_skid_push = in_valid & ~w_skid_full & r_valid & ~out_ready;
    assign w_skid_pop  = w_skid_full & w_load;

    pipe_skid_buf #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .CLK     (CLK),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_skid_push),
        .i_pop   (w_skid_pop),
        .i_data  (in_data),
        .i_ctrl  (in_ctrl),
        .o_full  (w_skid_full),
        .o_data  (w_skid_data),
        .o_ctrl  (w_skid_ctrl)
    );

    assign in_ready = ~w_skid_full;

    // Older skid word has priority over the incoming one to keep ordering
    always_comb begin
        w_src_valid = in_valid;
        w_src_data  = in_data;
        w_src_ctrl  = in_ctrl;
        if (w_skid_full) begin
            w_src_valid = 1'b1;
            w_src_data  = w_skid_data;
            w_src_ctrl  = w_skid_ctrl;
        end
    end
`else
    assign in_ready = w_load;

    always_comb begin
        w_src_valid = in_valid;
        w_src_data  = in_data;
        w_src_ctrl  = in_ctrl;
    end
`endif

    // Main register: flush, then load, then hold
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_data  <= DATA_RST;
            r_ctrl  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (w_load) begin
            r_valid <= w_src_valid;
            r_data  <= w_src_data;
            r_ctrl  <= w_src_valid ? w_src_ctrl : '0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ctrl  = r_ctrl;

    // A bubble must never carry RegWrite/MemWrite
    a_bubble_ctrl: assert property (@(posedge CLK) disable iff (!rst)
        !r_valid |-> (r_ctrl == '0));

`ifdef PIPE_SKID_EN
    a_skid_behind_main: assert property (@(posedge CLK) disable iff (!rst)
        w_skid_full |-> r_valid);
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; a FIFO reference model tracks accepted words and flushes.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = EXMEM_DATA_W;
    localparam int unsigned CW = EXMEM_CTRL_W;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;

    item_t sb[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    always #5 CLK = ~CLK;

    pipe_stage_reg #(
        .DATA_W   (DW),
        .CTRL_W   (CW),
        .DATA_RST ('0)
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    // Reference acceptance: capacity 2 with skid, else 1 with pass-through ready
    function automatic bit exp_ready();
`ifdef PIPE_SKID_EN
        return sb.size() < 2;
`else
        return (sb.size() == 0) || out_ready;
`endif
    endfunction

    // Advance one clock and update the scoreboard the way the stage should
    task automatic tick();
        bit    acc;
        bit    xfer;
        bit    fl;
        item_t it;
        acc  = in_valid && exp_ready();
        xfer = (sb.size() > 0) && out_ready;
        fl   = flush;
        it   = '{d: in_data, c: in_ctrl};
        @(posedge CLK);
        if (xfer) void'(sb.pop_front());
        if (fl) sb.delete();
        else if (acc) sb.push_back(it);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_ctrl !== '0) $display("FAIL reset_ctrl: got %b want 000", out_ctrl); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_data: got %h want 0", out_data); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else n_pass++;
        @(posedge CLK); #1;
        // Stream 1..5, then pull reset mid-stream with words still held
        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            in_valid = 1'b1; in_data = DW'(n); in_ctrl = 3'b011;
            if (n == 3) out_ready = 1'b1;
            #1; tick();
        end
        n_checks++; if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", out_valid); else n_pass++;
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL async_reset_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_ctrl !== '0) $display("FAIL async_reset_ctrl: got %b want 000", out_ctrl); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL async_reset_data: got %h want 0", out_data); else n_pass++;
        sb.delete();
        @(posedge CLK); #2;
        rst = 1'b1;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_ready: got %b want 1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL post_reset_empty: got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1; flush = 1'b0;
        for (int n = 0; n < 8; n++) begin
            in_valid = 1'b1; in_data = DW'(32'hA0 + n); in_ctrl = 3'b101;
            #1;
            n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready[%0d]: got %b want 1", n, in_ready); else n_pass++;
            tick();
            n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %b want 1", n, out_valid); else n_pass++;
            n_checks++; if (out_data !== DW'(32'hA0 + n)) $display("FAIL stream_data[%0d]: got %h want %h", n, out_data, 32'hA0 + n); else n_pass++;
            n_checks++; if (out_ctrl !== 3'b101) $display("FAIL stream_ctrl[%0d]: got %b want 101", n, out_ctrl); else n_pass++;
        end
        idle(3);
    endtask

    task automatic test_stall();
        bit acc;
        bit want_rdy;
        in_valid = 1'b1; in_data = DW'(32'h55); in_ctrl = 3'b001; out_ready = 1'b1;
        #1; tick();
        out_ready = 1'b0; in_data = DW'(32'h56);
        for (int k = 0; k < 3; k++) begin
            #1;
`ifdef PIPE_SKID_EN
            want_rdy = (k == 0);
`else
            want_rdy = 1'b0;
`endif
            n_checks++; if (in_ready !== want_rdy) $display("FAIL stall_ready[%0d]: got %b want %b", k, in_ready, want_rdy); else n_pass++;
            acc = in_valid && exp_ready();
            tick();
            if (acc) in_valid = 1'b0;
            n_checks++; if (out_data !== DW'(32'h55)) $display("FAIL stall_hold[%0d]: got %h want 55", k, out_data); else n_pass++;
            n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); else n_pass++;
        end
        out_ready = 1'b1;
        #1; tick();
        in_valid = 1'b0;
        n_checks++; if (out_data !== DW'(32'h56)) $display("FAIL stall_order: got %h want 56", out_data); else n_pass++;
        n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_second_valid: got %b want 1", out_valid); else n_pass++;
        #1; tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_drained: got %b want 0", out_valid); else n_pass++;
        idle(2);
    endtask

    task automatic test_flush();
        in_valid = 1'b1; in_data = DW'(32'h77); in_ctrl = 3'b111; out_ready = 1'b0;
        #1; tick();
        in_valid = 1'b0;
        #1; tick();
        n_checks++; if (out_ctrl !== 3'b111) $display("FAIL flush_held_ctrl: got %b want 111", out_ctrl); else n_pass++;
        flush = 1'b1; in_valid = 1'b1; in_data = DW'(32'h99); in_ctrl = 3'b010;
        #1; tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_ctrl !== 3'b000) $display("FAIL flush_ctrl: got %b want 000", out_ctrl); else n_pass++;
        out_ready = 1'b1;
        #1; tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_dropped_word: got %b want 0", out_valid); else n_pass++;
        // Flush together with a downstream transfer and an upstream accept
        in_valid = 1'b1; in_data = DW'(32'h78); in_ctrl = 3'b111;
        #1; tick();
        flush = 1'b1; in_data = DW'(32'h9A);
        #1; tick();
        flush = 1'b0; in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_xfer_valid: got %b want 0", out_valid); else n_pass++;
        #1; tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_xfer_empty: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_ctrl !== 3'b000) $display("FAIL flush_xfer_ctrl: got %b want 000", out_ctrl); else n_pass++;
    endtask

`ifdef PIPE_SKID_EN
    task automatic test_flush_skid();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 3'b111;
        in_data = DW'(32'h10); #1; tick();
        in_data = DW'(32'h11); #1; tick();
        in_valid = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL skid_full_ready: got %b want 0", in_ready); else n_pass++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL skid_flush_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL skid_flush_ready: got %b want 1", in_ready); else n_pass++;
        out_ready = 1'b1;
        #1; tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL skid_flush_drain: got %b want 0", out_valid); else n_pass++;
    endtask
`endif

    task automatic test_random();
        item_t exp;
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = {5'($urandom), $urandom, $urandom};
            in_ctrl   = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            #1;
            n_checks++; if (in_ready !== exp_ready()) $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, exp_ready()); else n_pass++;
            tick();
            n_checks++; if (out_valid !== (sb.size() > 0)) $display("FAIL rand_valid[%0d]: got %b want %b", n, out_valid, sb.size() > 0); else n_pass++;
            if (sb.size() > 0) begin
                exp = sb[0];
                n_checks++; if (out_data !== exp.d || out_ctrl !== exp.c)
                    $display("FAIL rand_word[%0d]: got %h/%b want %h/%b", n, out_data, out_ctrl, exp.d, exp.c);
                else n_pass++;
            end else begin
                n_checks++; if (out_ctrl !== '0) $display("FAIL rand_bubble_ctrl[%0d]: got %b want 000", n, out_ctrl); else n_pass++;
            end
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
`ifdef PIPE_SKID_EN
        test_flush_skid();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
